// File: rtl/arbitro_escritura_pkg.sv
// Shared definitions for the register-file write arbiter and its load scoreboard.
// Widths, the register-index type and the priority/source encodings live here.
package arbitro_pkg;

  localparam int XLEN      = 32;
  localparam int NREG      = 32;
  localparam int REG_IDX_W = 5;

  typedef logic [REG_IDX_W-1:0] reg_idx_t;

  typedef enum logic {
    PRIO_ALU = 1'b0,
    PRIO_MEM = 1'b1
  } prio_t;

  // Which requester produced the write currently held in the output stage
  typedef enum logic {
    SRC_ALU = 1'b0,
    SRC_MEM = 1'b1
  } src_t;

endpackage

// File: rtl/arbitro_escritura_marcador.sv
// Load scoreboard: one pending bit per architectural register, set on reservation,
// cleared when the load writeback commits; x0 is never pending.
module marcador_registros #(
  parameter int NREG = arbitro_pkg::NREG
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 set_valid,
  input  arbitro_pkg::reg_idx_t set_reg,
  input  logic                 clr_valid,
  input  arbitro_pkg::reg_idx_t clr_reg,
  input  arbitro_pkg::reg_idx_t read_reg1,
  input  arbitro_pkg::reg_idx_t read_reg2,
  output logic [NREG-1:0]      pending,
  output logic                 stall
);

  logic [NREG-1:0] pending_next;

  // Clear first, then set, so a reservation racing a commit of the same register wins
  always_comb begin
    pending_next = pending;
    if (clr_valid) begin
      pending_next[clr_reg] = 1'b0;
    end
    if (set_valid && (set_reg != '0)) begin
      pending_next[set_reg] = 1'b1;
    end
    pending_next[0] = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pending <= '0;
    end else begin
      pending <= pending_next;
    end
  end

  assign stall = pending[read_reg1] | pending[read_reg2];

endmodule

// File: rtl/arbitro_escritura.sv
// Round-robin arbiter between ALU and load writebacks for the single register-file
// write port, with a registered output stage and a load-destination scoreboard.
module arbitro_escritura #(
  parameter int XLEN = arbitro_pkg::XLEN,
  parameter int NREG = arbitro_pkg::NREG
) (
  input  logic            CLK,
  input  logic            RST,
  input  logic            aluValid,
  output logic            aluReady,
  input  logic [4:0]      aluReg,
  input  logic [XLEN-1:0] aluData,
  input  logic            memValid,
  output logic            memReady,
  input  logic [4:0]      memReg,
  input  logic [XLEN-1:0] memData,
  input  logic            resValid,
  input  logic [4:0]      resReg,
  input  logic [4:0]      readReg1,
  input  logic [4:0]      readReg2,
  output logic            stall,
  output logic            RegWrite,
  output logic [4:0]      writeReg,
  output logic [XLEN-1:0] writeData,
  output logic [NREG-1:0] pending
);

  import arbitro_pkg::*;

  prio_t prio_q;
  src_t  src_q;
  logic  grant_alu;
  logic  grant_mem;
  logic  mem_commit;

  // Each ready is derived from the valids and priority only, never from the other ready
  always_comb begin
    grant_alu = 1'b0;
    grant_mem = 1'b0;
    if (!RST) begin
      if (aluValid && memValid) begin
        grant_alu = (prio_q == PRIO_ALU);
        grant_mem = (prio_q == PRIO_MEM);
      end else begin
        grant_alu = aluValid;
        grant_mem = memValid;
      end
    end
  end

  assign aluReady = grant_alu;
  assign memReady = grant_mem;

  // Writes to x0 are consumed but never raise RegWrite
  always_ff @(posedge CLK) begin
    if (RST) begin
      prio_q    <= PRIO_ALU;
      src_q     <= SRC_ALU;
      RegWrite  <= 1'b0;
      writeReg  <= '0;
      writeData <= '0;
    end else if (grant_alu) begin
      prio_q    <= PRIO_MEM;
      src_q     <= SRC_ALU;
      RegWrite  <= (aluReg != '0);
      writeReg  <= aluReg;
      writeData <= aluData;
    end else if (grant_mem) begin
      prio_q    <= PRIO_ALU;
      src_q     <= SRC_MEM;
      RegWrite  <= (memReg != '0);
      writeReg  <= memReg;
      writeData <= memData;
    end else begin
      RegWrite  <= 1'b0;
    end
  end

  assign mem_commit = RegWrite && (src_q == SRC_MEM);

  marcador_registros #(
    .NREG(NREG)
  ) u_marcador (
    .clk       (CLK),
    .rst       (RST),
    .set_valid (resValid),
    .set_reg   (resReg),
    .clr_valid (mem_commit),
    .clr_reg   (writeReg),
    .read_reg1 (readReg1),
    .read_reg2 (readReg2),
    .pending   (pending),
    .stall     (stall)
  );

endmodule

// File: tb/tb_arbitro_escritura.sv
// Directed bench for arbitro_escritura: walks single writes, round-robin, the
// load scoreboard and reset behaviour with hand-computed expectations.
module tb_arbitro_escritura;

  logic        CLK = 1'b0;
  logic        RST;
  logic        aluValid, memValid, resValid;
  logic        aluReady, memReady;
  logic [4:0]  aluReg, memReg, resReg, readReg1, readReg2;
  logic [31:0] aluData, memData;
  logic        stall, RegWrite;
  logic [4:0]  writeReg;
  logic [31:0] writeData;
  logic [31:0] pending;

  int checks   = 0;
  int failures = 0;

  arbitro_escritura #(.XLEN(32), .NREG(32)) dut (
    .CLK(CLK), .RST(RST),
    .aluValid(aluValid), .aluReady(aluReady), .aluReg(aluReg), .aluData(aluData),
    .memValid(memValid), .memReady(memReady), .memReg(memReg), .memData(memData),
    .resValid(resValid), .resReg(resReg),
    .readReg1(readReg1), .readReg2(readReg2),
    .stall(stall), .RegWrite(RegWrite), .writeReg(writeReg), .writeData(writeData),
    .pending(pending)
  );

  always #5 CLK = ~CLK;

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [63:0] observed,
                             input logic [63:0] expected);
    checks++;
    assert (observed === expected)
    else begin
      failures++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  task automatic applyStimulus(input logic av, input logic [4:0] ar, input logic [31:0] ad,
                               input logic mv, input logic [4:0] mr, input logic [31:0] md);
    aluValid = av; aluReg = ar; aluData = ad;
    memValid = mv; memReg = mr; memData = md;
  endtask

  initial begin
    RST = 1'b1; resValid = 1'b0; resReg = '0; readReg1 = '0; readReg2 = '0;
    applyStimulus(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0);
    tick(); tick();

    // Reset state: readies forced low even with both requesters valid
    applyStimulus(1'b1, 5'd4, 32'h4, 1'b1, 5'd6, 32'h6);
    #1;
    checkOutput("rst_aluReady", aluReady, 0);
    checkOutput("rst_memReady", memReady, 0);
    checkOutput("rst_RegWrite", RegWrite, 0);
    checkOutput("rst_writeReg", writeReg, 0);
    checkOutput("rst_writeData", writeData, 0);
    checkOutput("rst_pending", pending, 0);
    checkOutput("rst_stall", stall, 0);
    applyStimulus(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0);
    RST = 1'b0;
    tick();

    // Single ALU write
    applyStimulus(1'b1, 5'd5, 32'hA5A5A5A5, 1'b0, 5'd0, 32'h0);
    #1;
    checkOutput("alu1_aluReady", aluReady, 1);
    checkOutput("alu1_memReady", memReady, 0);
    tick();
    applyStimulus(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0);
    checkOutput("alu1_RegWrite", RegWrite, 1);
    checkOutput("alu1_writeReg", writeReg, 5);
    checkOutput("alu1_writeData", writeData, 32'hA5A5A5A5);
    tick();
    checkOutput("alu1_RegWrite_drop", RegWrite, 0);

    // Lone mem write is granted despite PRIO_MEM/ALU state and hands priority back to ALU
    applyStimulus(1'b0, 5'd0, 32'h0, 1'b1, 5'd3, 32'h33);
    #1;
    checkOutput("mem1_memReady", memReady, 1);
    checkOutput("mem1_aluReady", aluReady, 0);
    tick();
    applyStimulus(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0);
    checkOutput("mem1_RegWrite", RegWrite, 1);
    checkOutput("mem1_writeReg", writeReg, 3);
    checkOutput("mem1_writeData", writeData, 32'h33);
    tick();

    // Both valid for four cycles: ALU, MEM, ALU, MEM
    applyStimulus(1'b1, 5'd1, 32'h11, 1'b1, 5'd2, 32'h22);
    #1;
    for (int i = 0; i < 4; i++) begin
      checkOutput($sformatf("rr%0d_aluReady", i), aluReady, (i % 2 == 0) ? 1 : 0);
      checkOutput($sformatf("rr%0d_memReady", i), memReady, (i % 2 == 0) ? 0 : 1);
      tick();
      if (i == 3) applyStimulus(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0);
      checkOutput($sformatf("rr%0d_RegWrite", i), RegWrite, 1);
      checkOutput($sformatf("rr%0d_writeReg", i), writeReg, (i % 2 == 0) ? 1 : 2);
      checkOutput($sformatf("rr%0d_writeData", i), writeData, (i % 2 == 0) ? 32'h11 : 32'h22);
    end
    tick();
    checkOutput("rr_RegWrite_idle", RegWrite, 0);

    // Reserve x7, stall decode, then release it with a load writeback
    resValid = 1'b1; resReg = 5'd7; readReg1 = 5'd7;
    #1;
    checkOutput("res_stall_t", stall, 0);
    tick();
    resValid = 1'b0; resReg = 5'd0;
    checkOutput("res_stall_t1", stall, 1);
    checkOutput("res_pending_t1", pending, 32'h80);
    tick();
    checkOutput("res_stall_t2", stall, 1);
    tick();
    applyStimulus(1'b0, 5'd0, 32'h0, 1'b1, 5'd7, 32'h77);
    #1;
    checkOutput("res_memReady_t3", memReady, 1);
    tick();
    applyStimulus(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0);
    checkOutput("res_RegWrite_t4", RegWrite, 1);
    checkOutput("res_writeReg_t4", writeReg, 7);
    checkOutput("res_pending_t4", pending, 32'h80);
    checkOutput("res_stall_t4", stall, 1);
    tick();
    checkOutput("res_pending_t5", pending, 0);
    checkOutput("res_stall_t5", stall, 0);

    // Reservation coinciding with the commit of the same register keeps the bit
    resValid = 1'b1; resReg = 5'd7;
    tick();
    resValid = 1'b0;
    applyStimulus(1'b0, 5'd0, 32'h0, 1'b1, 5'd7, 32'h70);
    tick();
    applyStimulus(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0);
    resValid = 1'b1; resReg = 5'd7;
    checkOutput("race_RegWrite", RegWrite, 1);
    tick();
    resValid = 1'b0; resReg = 5'd0;
    readReg1 = 5'd0; readReg2 = 5'd7;
    #1;
    checkOutput("race_pending", pending, 32'h80);
    checkOutput("race_stall_rr2", stall, 1);
    readReg2 = 5'd0;
    #1;
    checkOutput("race_stall_clear", stall, 0);

    // ALU write to x0 is consumed silently; ALU writes leave pending alone
    applyStimulus(1'b1, 5'd0, 32'hDEAD, 1'b0, 5'd0, 32'h0);
    #1;
    checkOutput("x0_aluReady", aluReady, 1);
    tick();
    applyStimulus(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0);
    checkOutput("x0_RegWrite", RegWrite, 0);
    resValid = 1'b1; resReg = 5'd0;
    tick();
    resValid = 1'b0;
    checkOutput("x0_pending", pending, 32'h80);
    checkOutput("x0_pending_bit0", pending[0], 0);

    // Reset in the cycle of a requested write drops it and restores PRIO_ALU
    applyStimulus(1'b0, 5'd0, 32'h0, 1'b1, 5'd9, 32'h99);
    RST = 1'b1;
    #1;
    checkOutput("rst2_memReady", memReady, 0);
    tick();
    RST = 1'b0;
    applyStimulus(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0);
    checkOutput("rst2_RegWrite", RegWrite, 0);
    checkOutput("rst2_pending", pending, 0);
    checkOutput("rst2_writeReg", writeReg, 0);
    applyStimulus(1'b1, 5'd10, 32'hA, 1'b1, 5'd11, 32'hB);
    #1;
    checkOutput("rst2_prio_alu", aluReady, 1);
    checkOutput("rst2_prio_mem", memReady, 0);
    applyStimulus(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0);
    tick();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
